apb_multi_sampler: RTL



---
 rtl/apb_multi_sampler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/apb_multi_sampler.sv
// apb_multi_sampler: periodically snapshots NUM_CH data channels and writes every
//   enabled channel as an APB write (SETUP + ACCESS) to BASE_ADDR + 4*channel.
// Latency: psel rises the cycle after a divider tick; each channel takes 2 cycles plus wait states.
// Backpressure: pready=0 stretches ACCESS; ticks arriving while busy are dropped and flagged on overrun.
// Ports: pclk/preset (sync, active-high); data_i/ch_en sampled at tick; APB master outputs
//   psel/penable/paddr/pwdata/pwrite, pready/prdata inputs (prdata unused); busy/overrun/timeout status.
// Optional: `define APB_SAMPLER_TIMEOUT_EN aborts an ACCESS after TIMEOUT wait cycles
//   and pulses timeout; otherwise ACCESS waits indefinitely and timeout stays 0.
module apb_multi_sampler #(
  parameter int          NUM_CH    = 4,
  parameter int          DATA_W    = 32,
  parameter int          DIV       = 16,
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int          TIMEOUT   = 15
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic                     psel,
  output logic                     penable,
  output logic [7:0]               paddr,
  output logic [31:0]              pwdata,
  output logic                     pwrite,
  input  logic                     pready,
  input  logic [31:0]              prdata,
  output logic                     busy,
  output logic                     overrun,
  output logic                     timeout
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIV_W = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                          state, state_n;
  logic [DIV_W-1:0]                div_cnt;
  logic                            tick;
  logic [NUM_CH-1:0]               pending, pending_n;
  logic [NUM_CH-1:0][DATA_W-1:0]   snap, snap_n;
  logic [CH_W-1:0]                 cur_ch, lo_ch;
  logic                            load;       // a new channel enters SETUP next cycle
  logic                            done;       // current ACCESS finishes this cycle
  logic                            to_n;

  // Read data is never consumed by a write-only master.
  logic unused_prdata;
  assign unused_prdata = ^prdata;

  // Free-running sample divider, independent of the FSM.
  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge pclk) begin
    if (preset || tick) div_cnt <= '0;
    else                div_cnt <= div_cnt + 1'b1;
  end

`ifdef APB_SAMPLER_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Cleared while outside ACCESS, so every ACCESS entry starts from zero.
  always_ff @(posedge pclk) begin
    if (preset || state != ACCESS) wait_cnt <= '0;
    else if (!pready)              wait_cnt <= wait_cnt + 1'b1;
  end
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  always_comb begin
    state_n   = state;
    pending_n = pending;
    snap_n    = snap;
    load      = 1'b0;
    done      = 1'b0;
    to_n      = 1'b0;
    case (state)
      IDLE: begin
        if (tick && ch_en != '0) begin
          state_n   = SETUP;
          pending_n = ch_en;
          snap_n    = data_i;
          load      = 1'b1;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        done = pready;
`ifdef APB_SAMPLER_TIMEOUT_EN
        // This is the TIMEOUT-th cycle spent waiting: give up on the channel.
        if (!pready && wait_cnt == 8'(TIMEOUT - 1)) begin
          done = 1'b1;
          to_n = 1'b1;
        end
`endif
        if (done) begin
          pending_n = pending & ~(NUM_CH'(1) << cur_ch);
          if (pending_n != '0) begin
            state_n = SETUP;
            load    = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Lowest set bit of the mask the next SETUP will serve.
  always_comb begin
    lo_ch = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pending_n[k]) lo_ch = CH_W'(k);
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= IDLE;
      pending <= '0;
      snap    <= '0;
      cur_ch  <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      snap    <= snap_n;
      // Outputs are registered copies of the next state so psel lines up with SETUP.
      psel    <= (state_n != IDLE);
      penable <= (state_n == ACCESS);
      pwrite  <= (state_n != IDLE);
      busy    <= (state_n != IDLE);
      overrun <= tick && (state != IDLE);
      timeout <= to_n;
      // Address and data only move when a channel is launched; they hold through ACCESS and IDLE.
      if (load) begin
        cur_ch <= lo_ch;
        paddr  <= BASE_ADDR + (8'(lo_ch) << 2);
        pwdata <= 32'(snap_n[lo_ch]);
      end
    end
  end

endmodule
